lotr_ring_stop: RTL and testbench

- Parametrised ring stop that connects one LOTR tile to the ring.
- Generalises the fixed 32-bit address/data tile ring interface: adds a valid/opcode, a configurable tile-ID field, and NUM_CH local injection channels with round-robin arbitration.
- Adds a buffered ejection FIFO and a bounce path for packets that cannot be ejected.
- Keeps the Q500H-in / Q502H-out ring timing. Sits between the ring and the tile's core/fabric request logic.

---
 rtl/lotr_ring_stop.sv | 148 ++++++++++++++
 tb/tb_lotr_ring_stop.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/lotr_ring_stop.sv
// LOTR ring stop: Q500 ring input, Q501 decode/eject, Q502 registered ring output.
// Ejected packets free the slot for round-robin local injection; a full FIFO bounces hits.
module lotr_ring_stop #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int NUM_CH   = 2,
  parameter int EJ_DEPTH = 4,
  parameter int ID_MSB   = 31,
  parameter int ID_LSB   = 24,
  parameter int CNT_W    = 16
) (
  input  logic                     QClk,
  input  logic                     RstQnnnH,
  input  logic [7:0]               tile_id,
  input  logic                     RingInputValidQ500H,
  input  logic [1:0]               RingInputOpcodeQ500H,
  input  logic [ADDR_W-1:0]        RingInputAddressQ500H,
  input  logic [DATA_W-1:0]        RingInputDataQ500H,
  output logic                     RingOutputValidQ502H,
  output logic [1:0]               RingOutputOpcodeQ502H,
  output logic [ADDR_W-1:0]        RingOutputAddressQ502H,
  output logic [DATA_W-1:0]        RingOutputDataQ502H,
  input  logic [NUM_CH-1:0]        InjValid,
  input  logic [2*NUM_CH-1:0]      InjOpcode,
  input  logic [ADDR_W*NUM_CH-1:0] InjAddress,
  input  logic [DATA_W*NUM_CH-1:0] InjData,
  output logic [NUM_CH-1:0]        InjReady,
  output logic                     EjValid,
  output logic [1:0]               EjOpcode,
  output logic [ADDR_W-1:0]        EjAddress,
  output logic [DATA_W-1:0]        EjData,
  input  logic                     EjReady,
  output logic [CNT_W-1:0]         BounceCnt
);
  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int AW    = $clog2(EJ_DEPTH);
  localparam int PW    = 2 + ADDR_W + DATA_W;

  logic              v1_q;
  logic [1:0]        op1_q;
  logic [ADDR_W-1:0] a1_q;
  logic [DATA_W-1:0] d1_q;

  logic              v2_q, v2_d;
  logic [1:0]        op2_q, op2_d;
  logic [ADDR_W-1:0] a2_q, a2_d;
  logic [DATA_W-1:0] d2_q, d2_d;

  logic [PTR_W-1:0]  rr_q, gnt_idx;
  logic              gnt_any;
  int                gi;
  logic [CNT_W-1:0]  bcnt_q;

  logic [PW-1:0]     mem_q [EJ_DEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [AW:0]       cnt_q;

  logic hit, full, push, bounce, fwd, slot_free, inj, ej_v, pop;

  assign hit       = v1_q && (a1_q[ID_MSB:ID_LSB] == tile_id);
  // Full uses the registered count, so a same-cycle pop never rescues a hit.
  assign full      = (cnt_q == (AW+1)'(EJ_DEPTH));
  assign push      = hit && !full;
  assign bounce    = hit && full;
  assign fwd       = v1_q && !push;
  assign slot_free = !fwd;
  assign ej_v      = (cnt_q != '0);
  assign pop       = ej_v && EjReady;

  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!gnt_any && InjValid[(int'(rr_q) + k) % NUM_CH]) begin
        gnt_any = 1'b1;
        gnt_idx = PTR_W'((int'(rr_q) + k) % NUM_CH);
      end
    end
    gi = int'(gnt_idx);
  end

  assign inj      = slot_free && gnt_any;
  assign InjReady = inj ? (NUM_CH'(1) << gnt_idx) : '0;

  always_comb begin
    v2_d  = 1'b0;
    op2_d = '0;
    a2_d  = '0;
    d2_d  = '0;
    if (fwd) begin
      v2_d  = 1'b1;
      op2_d = op1_q;
      a2_d  = a1_q;
      d2_d  = d1_q;
    end else if (inj) begin
      v2_d  = 1'b1;
      op2_d = InjOpcode[2*gi +: 2];
      a2_d  = InjAddress[gi*ADDR_W +: ADDR_W];
      d2_d  = InjData[gi*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge QClk) begin
    if (!RstQnnnH) begin
      v1_q   <= 1'b0;
      op1_q  <= '0;
      a1_q   <= '0;
      d1_q   <= '0;
      v2_q   <= 1'b0;
      op2_q  <= '0;
      a2_q   <= '0;
      d2_q   <= '0;
      rr_q   <= '0;
      bcnt_q <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
    end else begin
      v1_q  <= RingInputValidQ500H;
      op1_q <= RingInputOpcodeQ500H;
      a1_q  <= RingInputAddressQ500H;
      d1_q  <= RingInputDataQ500H;
      v2_q  <= v2_d;
      op2_q <= op2_d;
      a2_q  <= a2_d;
      d2_q  <= d2_d;
      if (inj) rr_q <= PTR_W'((gi + 1) % NUM_CH);
      if (bounce && (bcnt_q != '1)) bcnt_q <= bcnt_q + CNT_W'(1);
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge QClk) begin
    if (push) mem_q[wr_q] <= {op1_q, a1_q, d1_q};
  end

  assign RingOutputValidQ502H   = v2_q;
  assign RingOutputOpcodeQ502H  = op2_q;
  assign RingOutputAddressQ502H = a2_q;
  assign RingOutputDataQ502H    = d2_q;

  assign EjValid = ej_v;
  assign {EjOpcode, EjAddress, EjData} = ej_v ? mem_q[rd_q] : '0;
  assign BounceCnt = bcnt_q;
endmodule

// File: tb/tb_lotr_ring_stop.sv
// Randomized bench for lotr_ring_stop against a transaction-level model
// (queue for the ejection FIFO, one-packet delay for Q501, integer RR pointer).
module tb_lotr_ring_stop;
  localparam int AW = 32, DW = 32, NC = 2, DEP = 4, CW = 4;

  logic              QClk = 1'b0;
  logic              RstQnnnH;
  logic [7:0]        tile_id;
  logic              RingInputValidQ500H;
  logic [1:0]        RingInputOpcodeQ500H;
  logic [AW-1:0]     RingInputAddressQ500H;
  logic [DW-1:0]     RingInputDataQ500H;
  logic              RingOutputValidQ502H;
  logic [1:0]        RingOutputOpcodeQ502H;
  logic [AW-1:0]     RingOutputAddressQ502H;
  logic [DW-1:0]     RingOutputDataQ502H;
  logic [NC-1:0]     InjValid;
  logic [2*NC-1:0]   InjOpcode;
  logic [AW*NC-1:0]  InjAddress;
  logic [DW*NC-1:0]  InjData;
  logic [NC-1:0]     InjReady;
  logic              EjValid;
  logic [1:0]        EjOpcode;
  logic [AW-1:0]     EjAddress;
  logic [DW-1:0]     EjData;
  logic              EjReady;
  logic [CW-1:0]     BounceCnt;

  lotr_ring_stop #(.ADDR_W(AW), .DATA_W(DW), .NUM_CH(NC), .EJ_DEPTH(DEP),
                   .ID_MSB(31), .ID_LSB(24), .CNT_W(CW)) dut (
    .QClk(QClk), .RstQnnnH(RstQnnnH), .tile_id(tile_id),
    .RingInputValidQ500H(RingInputValidQ500H), .RingInputOpcodeQ500H(RingInputOpcodeQ500H),
    .RingInputAddressQ500H(RingInputAddressQ500H), .RingInputDataQ500H(RingInputDataQ500H),
    .RingOutputValidQ502H(RingOutputValidQ502H), .RingOutputOpcodeQ502H(RingOutputOpcodeQ502H),
    .RingOutputAddressQ502H(RingOutputAddressQ502H), .RingOutputDataQ502H(RingOutputDataQ502H),
    .InjValid(InjValid), .InjOpcode(InjOpcode), .InjAddress(InjAddress), .InjData(InjData),
    .InjReady(InjReady), .EjValid(EjValid), .EjOpcode(EjOpcode), .EjAddress(EjAddress),
    .EjData(EjData), .EjReady(EjReady), .BounceCnt(BounceCnt)
  );

  always #5 QClk = ~QClk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] d;
  } pkt_t;

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model state
  bit   s1_v;
  pkt_t s1;
  bit   ev;
  pkt_t eo;
  pkt_t fq[$];
  int   bcnt, rr;

  function automatic int model_grant();
    bool_fwd: begin end
    if (s1_v && !(s1.a[31:24] == tile_id && fq.size() < DEP)) return -1;
    for (int k = 0; k < NC; k++)
      if (InjValid[(rr + k) % NC]) return (rr + k) % NC;
    return -1;
  endfunction

  task automatic model_step();
    bit hit, full;
    int g;
    if (!RstQnnnH) begin
      s1_v = 0; s1 = '{2'b0, 32'b0, 32'b0};
      ev = 0;   eo = '{2'b0, 32'b0, 32'b0};
      fq.delete(); bcnt = 0; rr = 0;
      return;
    end
    hit  = s1_v && (s1.a[31:24] == tile_id);
    full = (fq.size() == DEP);
    g    = model_grant();
    if (s1_v && !(hit && !full)) begin
      ev = 1; eo = s1;
    end else if (g >= 0) begin
      ev = 1;
      eo = '{InjOpcode[2*g +: 2], InjAddress[g*AW +: AW], InjData[g*DW +: DW]};
      rr = (g + 1) % NC;
    end else begin
      ev = 0; eo = '{2'b0, 32'b0, 32'b0};
    end
    if (hit && full && bcnt < (1 << CW) - 1) bcnt++;
    if (fq.size() > 0 && EjReady) void'(fq.pop_front());
    if (hit && !full) fq.push_back(s1);
    s1_v = RingInputValidQ500H;
    s1   = '{RingInputOpcodeQ500H, RingInputAddressQ500H, RingInputDataQ500H};
  endtask

  // Per-phase percentages: ring valid, ring hit, injection valid, EjReady
  int pv_t[6] = '{50, 80,   0, 100,  50, 30};
  int ph_t[6] = '{50, 90,   0,  20,  70, 50};
  int pi_t[6] = '{50, 30, 100,  80,  60, 50};
  int pe_t[6] = '{50, 10,  50,  50, 100, 30};

  initial begin
    int   rcnt, ph, exp_g;
    logic [7:0] tid, tgt;
    pkt_t hd;
    rcnt = 0;
    tid  = 8'h02;
    RstQnnnH = 1'b0; tile_id = tid; EjReady = 1'b0;
    RingInputValidQ500H = 1'b0; RingInputOpcodeQ500H = '0;
    RingInputAddressQ500H = '0; RingInputDataQ500H = '0;
    InjValid = '0; InjOpcode = '0; InjAddress = '0; InjData = '0;
    for (int cyc = 0; cyc < 1800; cyc++) begin
      @(negedge QClk);
      if (cyc > 0) begin
        chk("q502_valid", RingOutputValidQ502H, ev);
        chk("q502_op",    RingOutputOpcodeQ502H, eo.op);
        chk("q502_addr",  RingOutputAddressQ502H, eo.a);
        chk("q502_data",  RingOutputDataQ502H, eo.d);
        chk("ej_valid",   EjValid, fq.size() > 0);
        if (fq.size() > 0) begin
          hd = fq[0];
          chk("ej_head", {EjOpcode, EjAddress, EjData}, {hd.op, hd.a, hd.d});
        end
        chk("bounce_cnt", BounceCnt, bcnt);
      end
      ph = cyc / 300;
      if (cyc < 3) RstQnnnH = 1'b0;
      else if (rcnt > 0) begin RstQnnnH = 1'b0; rcnt--; end
      else begin
        RstQnnnH = 1'b1;
        if ($urandom_range(0, 249) == 0) rcnt = $urandom_range(1, 3);
      end
      if (!RstQnnnH && cyc >= 3) tid = 8'($urandom_range(0, 3));
      tile_id = tid;
      RingInputValidQ500H  = ($urandom_range(0, 99) < pv_t[ph]);
      tgt = ($urandom_range(0, 99) < ph_t[ph]) ? tid : (tid ^ 8'($urandom_range(1, 255)));
      RingInputAddressQ500H = {tgt, 24'($urandom)};
      RingInputOpcodeQ500H  = 2'($urandom);
      RingInputDataQ500H    = $urandom;
      for (int i = 0; i < NC; i++) begin
        InjValid[i] = ($urandom_range(0, 99) < pi_t[ph]);
        InjOpcode[2*i +: 2] = 2'($urandom);
        InjAddress[i*AW +: AW] = ($urandom_range(0, 3) == 0) ? {tid, 24'($urandom)} : $urandom;
        InjData[i*DW +: DW] = $urandom;
      end
      EjReady = ($urandom_range(0, 99) < pe_t[ph]);
      #1;
      if (cyc > 0) begin
        exp_g = model_grant();
        chk("inj_ready", InjReady, (exp_g >= 0) ? (NC'(1) << exp_g) : NC'(0));
      end
      @(posedge QClk);
      model_step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
